// File: rtl/vga_pkg.sv
// Shared VGA timing constants, update-client indices and the scheduler state
// encoding used by the vblank update scheduler.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      REQ    = 2'd2,
      GAP    = 2'd3
   } state_t;

   localparam int HD   = 640;
   localparam int VD   = 480;
   localparam int HMAX = 799;
   localparam int VMAX = 524;

   localparam int CL_LPAD  = 0;
   localparam int CL_RPAD  = 1;
   localparam int CL_BALL  = 2;
   localparam int CL_SCORE = 3;

endpackage

// File: rtl/vblank_edge_detect.sv
// Registers the vertical-blank level and produces one-cycle pulses on
// entry into blanking (frame_start) and on return to active video.
module vblank_edge_detect #(
   parameter int VD = vga_pkg::VD
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [9:0] y,
   output logic       frame_start,
   output logic       video_start
);

   logic vb;
   logic vb_q;

   assign vb = (y >= 10'(VD));

   always_ff @(posedge clk_100MHz) begin
      if (reset) vb_q <= 1'b0;
      else       vb_q <= vb;
   end

   assign frame_start = vb & ~vb_q;
   assign video_start = ~vb & vb_q;

endmodule

// File: rtl/vblank_update_scheduler.sv
// Commits shadow configuration at the start of vertical blanking, then walks
// each update client through a req/ack handshake before active video resumes.
module vblank_update_scheduler
   import vga_pkg::*;
#(
   parameter int VD          = vga_pkg::VD,
   parameter int NUM_CLIENTS = 4,
   parameter int TIMEOUT     = 1024,
   parameter int CFG_W       = 32
) (
   input  logic                   clk_100MHz,
   input  logic                   reset,
   input  logic [9:0]             y,
   input  logic [CFG_W-1:0]       cfg_in,
   input  logic [NUM_CLIENTS-1:0] upd_ack,
   input  logic                   clr_status,
   output logic [NUM_CLIENTS-1:0] upd_req,
   output logic [CFG_W-1:0]       cfg_active,
   output logic                   cfg_commit,
   output logic                   busy,
   output logic [15:0]            frame_cnt,
   output logic                   overrun,
   output logic [NUM_CLIENTS-1:0] timeout_err
);

   localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   state_t                   state;
   state_t                   state_nxt;
   logic [IDX_W-1:0]         idx;
   logic [TO_W-1:0]          to_cnt;
   logic                     frame_start;
   logic                     video_start;
   logic                     ack_cur;
   logic                     to_hit;
   logic                     overrun_set;
   logic [NUM_CLIENTS-1:0]   to_set;

   vblank_edge_detect #(
      .VD(VD)
   ) u_edge (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .y          (y),
      .frame_start(frame_start),
      .video_start(video_start)
   );

   assign ack_cur = upd_ack[idx];
   assign to_hit  = (to_cnt == TO_LAST);

   always_ff @(posedge clk_100MHz) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Active video returning aborts the walk; it outranks ack and timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = COMMIT;
         COMMIT:  state_nxt = (video_start || cfg_in[0]) ? IDLE : REQ;
         REQ: begin
            if (video_start)            state_nxt = IDLE;
            else if (ack_cur || to_hit) state_nxt = GAP;
         end
         GAP: begin
            if (video_start || idx == IDX_LAST) state_nxt = IDLE;
            else                                state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      upd_req    = '0;
      cfg_commit = 1'b0;
      busy       = 1'b0;
      case (state)
         COMMIT: begin
            cfg_commit = 1'b1;
            busy       = 1'b1;
         end
         REQ: begin
            upd_req[idx] = 1'b1;
            busy         = 1'b1;
         end
         GAP:     busy = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      overrun_set = video_start && (state != IDLE);
      to_set      = '0;
      if (state == REQ && !video_start && !ack_cur && to_hit) to_set[idx] = 1'b1;
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         idx         <= '0;
         to_cnt      <= '0;
         cfg_active  <= '0;
         frame_cnt   <= '0;
         overrun     <= 1'b0;
         timeout_err <= '0;
      end else begin
         case (state)
            COMMIT: begin
               cfg_active <= cfg_in;
               frame_cnt  <= frame_cnt + 16'd1;
               idx        <= '0;
               to_cnt     <= '0;
            end
            REQ: begin
               if (video_start) begin
                  idx    <= '0;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            GAP: begin
               to_cnt <= '0;
               if (video_start)           idx <= '0;
               else if (idx != IDX_LAST)  idx <= idx + IDX_W'(1);
            end
            default: ;
         endcase

         // A flag being set in the same cycle as clr_status stays set.
         if (overrun_set)     overrun <= 1'b1;
         else if (clr_status) overrun <= 1'b0;
         timeout_err <= (clr_status ? '0 : timeout_err) | to_set;
      end
   end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Sequences per-frame game-state updates (paddles, ball, score) inside the vertical blanking interval of the 640x480 VGA timing generator.
- Watches the timing generator's y count. At the first blanking line it commits CPU/AXI-written configuration into a shadow register and increments a frame counter.
- It then walks each update client through a req/ack handshake in fixed order.
- It aborts with a sticky overrun flag if active video restarts before all clients finish.

Parameters:
- VD, 480, vertical display lines; blanking is y >= VD.
- NUM_CLIENTS, 4, number of update clients (index 0 = highest priority/first).
- TIMEOUT, 1024, max cycles a client may hold off ack.
- CFG_W, 32, width of configuration word.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- y  in  10  vertical pixel count from the timing generator.
- cfg_in  in  CFG_W  configuration from the AXI register file; cfg_in[0] = pause.
- upd_ack  in  NUM_CLIENTS  per-client done acknowledge.
- clr_status  in  1  clears the overrun and timeout_err flags.
- upd_req  out  NUM_CLIENTS  one-hot update request.
- cfg_active  out  CFG_W  shadow config, stable for the whole frame.
- cfg_commit  out  1  one-cycle pulse when cfg_active loads.
- busy  out  1  high in COMMIT/REQ/GAP.
- frame_cnt  out  16  frames started since reset; wraps.
- overrun  out  1  sticky; the sequence was aborted by active video.
- timeout_err  out  NUM_CLIENTS  sticky per-client timeout flags.

Behaviour:
- Reset values: all outputs 0, state IDLE, idx 0, timeout counter 0, vb_q 0.
- Blanking detect:
  - vb = (y >= VD); vb_q is vb registered every clock.
  - frame_start = vb & ~vb_q.
  - video_start = ~vb & vb_q.
- States and transitions:
  - IDLE: on frame_start go to COMMIT. Otherwise stay.
  - COMMIT (1 cycle): cfg_commit=1. cfg_active<=cfg_in and frame_cnt<=frame_cnt+1, both visible the next cycle. If cfg_in[0] (pause) is set, go to IDLE; otherwise go to REQ with idx=0.
  - REQ: upd_req = 1<<idx and the timeout counter increments each cycle.
    - On upd_ack[idx]: go to GAP.
    - Else if the counter equals TIMEOUT-1: timeout_err[idx]<=1, go to GAP.
  - GAP (1 cycle, upd_req=0): counter<=0. If idx==NUM_CLIENTS-1, go to IDLE; else idx<=idx+1 and go to REQ.
- Latency: with y reaching VD in cycle N, cfg_commit is high in N+1 and upd_req[0] is first high in N+2.
- Handshake rules:
  - Only upd_ack[idx] is observed. Acks from other clients, and any ack in IDLE, COMMIT or GAP, are ignored.
  - Clients must drop ack when req falls.
  - Req stays high until an ack is sampled or the timeout fires.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins, no error bit is set.
  - video_start while in REQ or GAP: go to IDLE immediately, upd_req=0, overrun<=1, idx<=0. This takes priority over ack and timeout in that cycle.
  - video_start in COMMIT: complete the commit, then go to IDLE with overrun<=1.
  - frame_start in any state other than IDLE is ignored.
  - clr_status in the same cycle as a flag set: the set wins.
- Widths:
  - frame_cnt wraps 0xFFFF -> 0x0000.
  - The timeout counter is $clog2(TIMEOUT) bits.
  - idx is $clog2(NUM_CLIENTS) bits, minimum 1.
- Reset mid-operation: all state returns to reset values; any asserted upd_req drops in the cycle after reset is sampled.

Decomposition:
- Shared package vga_pkg holds:
  - state enum (IDLE, COMMIT, REQ, GAP)
  - timing constants: HD=640, VD=480, HMAX=799, VMAX=524
  - client index constants: CL_LPAD=0, CL_RPAD=1, CL_BALL=2, CL_SCORE=3
- One sub-module is natural: vblank_edge_detect, which produces the vb_q register and the frame_start/video_start pulses.
- The FSM, counters and flags stay in the top module.

Test Plan:
- Sweep y 479->480 with cfg_in=0x0000_0010 and all clients acking 3 cycles after req -> cfg_commit high 1 cycle, cfg_active=0x10, frame_cnt=1, upd_req sequence 0001,0010,0100,1000 with exactly one idle cycle between, busy low afterwards.
- Drive cfg_in[0]=1 at frame start -> frame_cnt increments, cfg_active loaded, upd_req stays 0 all frame.
- Client 2 never acks with TIMEOUT=1024 -> upd_req=0100 held exactly 1024 cycles, timeout_err=0100, client 3 still serviced; clr_status then clears timeout_err to 0.
- Client 1 stalls and y wraps 524->0 while upd_req=0010 -> upd_req=0 the next cycle, overrun=1, next frame starts at client 0.
- Ack asserted in the same cycle the timeout expires -> timeout_err unchanged; upd_ack for a non-current client -> ignored, req held.
- Preload frame_cnt to 0xFFFF via 65535 frame sweeps (or a forced start value) -> next frame gives 0x0000; reset asserted during REQ -> all outputs 0 the following cycle.
